x_div_seq: RTL and testbench
============================

Name: x_div_seq

Overview:
Iterative 32-bit divide sequencer for the execute stage. It accepts RV32M DIV/DIVU/REM/REMU operations from X and runs a radix-2 restoring divide over 32 iterations. It raises busy so the X stage holds, then presents the result for one cycle. It sits beside the single-cycle ALU and drives the X-stage stall together with w_miss/wait_load.

Parameters:
ALU_DIV, 6'd28, alucode for signed quotient
ALU_DIVU, 6'd29, alucode for unsigned quotient
ALU_REM, 6'd30, alucode for signed remainder
ALU_REMU, 6'd31, alucode for unsigned remainder

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous active-low reset (0 = reset, sampled on rising edge of clk)
start  input  1  X-stage instruction valid this cycle (D_X_valid & !w_miss & !wait_load)
alucode  input  6  operation code; only the four parameter codes are acted on
op1  input  32  dividend
op2  input  32  divisor
kill  input  1  flush of the X-stage instruction (branch/jump redirect); aborts an operation in flight
busy  output  1  X-stage stall request
done  output  1  one-cycle pulse; result valid
result  output  32  quotient or remainder per latched alucode

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE, done=0, result=0, counter=0.
  - busy=0 while reset is held.
  - Reset mid-operation abandons the operation, with no done pulse.
- Accept condition: state==IDLE & start & alucode in {DIV,DIVU,REM,REMU} & !kill.
  - Any other start while not IDLE is ignored.
  - A non-div alucode is ignored.
- busy is combinational: (state==BUSY) | accept.
  - This stalls X in the accept cycle itself.
  - busy is 0 in IDLE and DONE.
- FSM states:
  - IDLE: on accept, latch op, sign flags, |op1|, |op2| (signed ops) or raw operands (unsigned ops).
    - If op2==0 or signed overflow, go to DONE.
    - Otherwise clear remainder, set counter=31, go to BUSY.
  - BUSY: one restoring step per cycle.
    - rem = {rem[30:0], dvd[31]}; dvd <<= 1.
    - If rem >= dvs, then rem -= dvs and dvd[0] = 1.
    - counter decrements; when the counter==0 step completes, go to DONE.
    - kill==1 goes to IDLE, with no done and result unchanged.
  - DONE: done=1 for exactly one cycle, result registered, then go to IDLE.
    - kill is ignored in DONE; the instruction has already completed.
- Latency:
  - Accept at cycle t: normal ops have done at t+33, with busy high t..t+32.
  - Special cases have done at t+1, with busy high at t only.
- Sign correction, applied on entry to DONE:
  - Quotient is negated when sign(op1)^sign(op2) for DIV.
  - Remainder takes sign(op1) for REM.
  - Unsigned ops are not corrected.
- Divide by zero (RISC-V spec): quotient=32'hFFFFFFFF (all op types); remainder=op1.
- Signed overflow (op1==32'h80000000, op2==32'hFFFFFFFF, DIV/REM only): quotient=32'h80000000, remainder=0.
- result holds its value after done until the next DONE entry; it is not cleared by kill.
- Back-to-back: an accept is legal in the cycle immediately after DONE (state is IDLE again).
- kill and start together in IDLE: no accept, and busy=0.

Test Plan:
- Basic DIV: accept DIV 100/7 at t -> busy=1 for t..t+32; done=1 at t+33 only; result=14. Repeat with REM -> result=2.
- Signed mix: REM -20/6 -> result=32'hFFFFFFFE (-2); DIV -20/6 -> 32'hFFFFFFFD (-3); DIVU 32'hFFFFFFEC/6 -> 32'h2AAAAAA7.
- Special cases:
  - DIVU 5/0 -> done at t+1, result=32'hFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 32'h80000000/32'hFFFFFFFF -> 32'h80000000.
  - REM of the same operands -> 0.
  - All of these hold busy for 1 cycle only.
- Kill: accept DIV 1000/3, assert kill at t+10 -> state IDLE at t+11; busy=0 from t+11; no done pulse; previous result retained. New DIV 9/3 accepted at t+12 -> result=3 at t+45.
- Ignored requests:
  - start with ADD alucode -> busy=0, no done.
  - start asserted during BUSY -> no effect on running result.
  - start+kill together -> not accepted.
- Reset: reset=0 at t+5 of a DIV -> done=0, result=0, busy=0 while reset low. Release, then DIVU 8/2 -> result=4 at t+33 after the new accept.

Source files
------------

// File: rtl/x_div_seq.sv
// rtl/x_div_seq.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// Holds the X stage via busy and presents the result with a one-cycle done pulse.
module x_div_seq #(
  parameter logic [5:0] ALU_DIV  = 6'd28,
  parameter logic [5:0] ALU_DIVU = 6'd29,
  parameter logic [5:0] ALU_REM  = 6'd30,
  parameter logic [5:0] ALU_REMU = 6'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  alucode,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_n;
  logic [4:0]  counter;
  logic [31:0] dvd, dvs, rem;
  logic        op_rem, neg_q, neg_r;

  logic        is_div_op, sgn_op, rem_op, accept;
  logic        div_zero, sgn_ovf, special;
  logic [31:0] abs1, abs2, spec_res;
  logic [32:0] rem_sh;
  logic [31:0] dvd_sh, rem_n, dvd_n, fin_res;

  assign is_div_op = (alucode == ALU_DIV) | (alucode == ALU_DIVU) |
                     (alucode == ALU_REM) | (alucode == ALU_REMU);
  assign sgn_op    = (alucode == ALU_DIV) | (alucode == ALU_REM);
  assign rem_op    = (alucode == ALU_REM) | (alucode == ALU_REMU);
  assign accept    = reset & (state == IDLE) & start & is_div_op & ~kill;

  assign busy = reset & ((state == BUSY) | accept);
  assign done = reset & (state == DONE);

  assign abs1 = (sgn_op & op1[31]) ? -op1 : op1;
  assign abs2 = (sgn_op & op2[31]) ? -op2 : op2;

  // Divide-by-zero and signed overflow bypass the iteration entirely
  assign div_zero = (op2 == 32'd0);
  assign sgn_ovf  = sgn_op & (op1 == 32'h8000_0000) & (op2 == 32'hFFFF_FFFF);
  assign special  = div_zero | sgn_ovf;
  assign spec_res = rem_op ? (div_zero ? op1 : 32'd0)
                           : (div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);

  // Partial remainder needs 33 bits: with a divisor above 2^31 the shift overflows 32
  assign rem_sh = {rem, dvd[31]};
  assign dvd_sh = {dvd[30:0], 1'b0};
  always_comb begin
    rem_n = rem_sh[31:0];
    dvd_n = dvd_sh;
    if (rem_sh >= {1'b0, dvs}) begin
      rem_n = rem_sh[31:0] - dvs;
      dvd_n = dvd_sh | 32'd1;
    end
  end

  assign fin_res = op_rem ? (neg_r ? -rem_n : rem_n)
                          : (neg_q ? -dvd_n : dvd_n);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = special ? DONE : BUSY;
      BUSY:    if (kill) state_n = IDLE;
               else if (counter == 5'd0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      counter <= 5'd0;
      result  <= 32'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_rem  <= rem_op;
          neg_q   <= sgn_op & (op1[31] ^ op2[31]);
          neg_r   <= sgn_op & op1[31];
          dvd     <= abs1;
          dvs     <= abs2;
          rem     <= 32'd0;
          counter <= 5'd31;
          if (special) result <= spec_res;
        end
        BUSY: if (!kill) begin
          dvd <= dvd_n;
          rem <= rem_n;
          if (counter != 5'd0) counter <= counter - 5'd1;
          else                 result  <= fin_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_x_div_seq.sv
// tb/tb_x_div_seq.sv - self-checking bench for x_div_seq
// Latency/result model compared every cycle, plus literal expectations per directed vector.
module tb_x_div_seq;

  localparam logic [5:0] DIV = 6'd28, DIVU = 6'd29, REM = 6'd30, REMU = 6'd31, ADD = 6'd0;

  logic        clk = 0, reset = 0, start = 0, kill = 0;
  logic [5:0]  alucode = 6'd0;
  logic [31:0] op1 = 0, op2 = 0;
  logic        busy, done;
  logic [31:0] result;

  int n_chk = 0, n_fail = 0, cyc = 0;

  x_div_seq dut (
    .clk(clk), .reset(reset), .start(start), .alucode(alucode),
    .op1(op1), .op2(op2), .kill(kill),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic bit is_div(input logic [5:0] c);
    return c inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic bit is_special(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || ((c == DIV || c == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V M semantics written straight from arithmetic
  function automatic logic [31:0] model(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    bit sgn;
    sa = a; sb = b;
    sgn = (c == DIV || c == REM);
    if (b == 0) begin q = 32'hFFFF_FFFF; r = a; end
    else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = 32'h8000_0000; r = 0; end
    else if (sgn) begin q = sa / sb; r = sa % sb; end
    else begin q = a / b; r = a % b; end
    return (c == REM || c == REMU) ? r : q;
  endfunction

  // Model state expressed as cycle numbers of the current operation
  int m_acc = -10, m_bend = -10, m_done = -10;
  logic [31:0] m_pend = 0, m_res = 0;

  initial begin
    bit in_busy, in_done, acc;
    @(posedge clk);
    forever begin
      @(negedge clk);
      in_busy = (cyc > m_acc) && (cyc <= m_bend);
      in_done = (cyc == m_done);
      if (in_done) m_res = m_pend;
      acc = reset && !in_busy && !in_done && start && is_div(alucode) && !kill;
      check("busy", {31'd0, busy}, {31'd0, reset && (in_busy || acc)});
      check("done", {31'd0, done}, {31'd0, reset && in_done});
      check("result", result, m_res);
      if (!reset) begin
        m_acc = -10; m_bend = -10; m_done = -10; m_res = 0;
      end else if (in_busy && kill) begin
        m_bend = -10; m_done = -10;
      end else if (acc) begin
        m_pend = model(alucode, op1, op2);
        m_acc  = cyc;
        if (is_special(alucode, op1, op2)) begin m_bend = cyc; m_done = cyc + 1; end
        else begin m_bend = cyc + 32; m_done = cyc + 33; end
      end
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lit, input int lat, input bit disturb);
    int t0;
    bit seen;
    alucode = c; op1 = a; op2 = b; start = 1; t0 = cyc;
    step();
    start = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        check("latency", cyc - t0, lat);
        check("literal", result, lit);
        break;
      end
      step();
      if (disturb) begin
        start = (i >= 2 && i < 5);
        alucode = DIV; op1 = 32'd50; op2 = 32'd5;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    start = 0;
    step();
  endtask

  initial begin
    int t0;
    repeat (3) step();
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result", result, 32'd0);
    step();
    reset = 1;
    step();

    do_op(DIV,  32'd100, 32'd7, 32'd14, 33, 0);
    do_op(REM,  32'd100, 32'd7, 32'd2,  33, 0);
    do_op(REM,  32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE, 33, 0);
    do_op(DIV,  32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, 33, 0);
    do_op(DIVU, 32'hFFFF_FFEC, 32'd6, 32'h2AAA_AAA7, 33, 0);
    do_op(DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
    do_op(DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 0);
    do_op(REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33, 0);
    do_op(DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    do_op(REM,  32'd5, 32'd0, 32'd5, 1, 0);
    do_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    do_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    do_op(DIV,  32'd100, 32'd7, 32'd14, 33, 1);

    // Kill mid-operation, then a fresh divide two cycles later
    alucode = DIV; op1 = 32'd1000; op2 = 32'd3; start = 1; t0 = cyc;
    step();
    start = 0;
    repeat (9) step();
    kill = 1;
    step();
    kill = 0;
    @(negedge clk);
    check("kill_busy", {31'd0, busy}, 32'd0);
    check("kill_result", result, 32'd14);
    step();
    do_op(DIV, 32'd9, 32'd3, 32'd3, 33, 0);

    // Non-div alucode and start+kill are ignored
    alucode = ADD; op1 = 32'd1; op2 = 32'd1; start = 1;
    @(negedge clk);
    check("add_busy", {31'd0, busy}, 32'd0);
    step();
    alucode = DIV; kill = 1;
    @(negedge clk);
    check("startkill_busy", {31'd0, busy}, 32'd0);
    step();
    start = 0; kill = 0;
    step();

    // Reset mid-operation
    alucode = DIV; op1 = 32'd1000; op2 = 32'd7; start = 1;
    step();
    start = 0;
    repeat (4) step();
    reset = 0;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    step();
    @(negedge clk);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    step();
    reset = 1;
    step();
    do_op(DIVU, 32'd8, 32'd2, 32'd4, 33, 0);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
